// File: rtl/alu_serial.sv
// Byte-serial multi-byte ALU: runs the 16-op 8-bit ALU instruction set over
// BYTES-byte operands through one 8-bit slice, one byte per clock, carrying
// the carry/borrow/shift bit between bytes in a single chain flop.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for start; result/flags hold last completed operation
// S_RUN  | one byte computed per cycle, byte counter counts down to zero
module alu_serial #(
   parameter int BYTES = 2,
   localparam int W = 8 * BYTES
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start,
   input  logic [3:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         invert,
   input  logic         carry_in,
   input  logic         n_oe,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic [3:0]   flags
);

   localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_ADC = 4'd2;
   localparam logic [3:0] OP_SBB = 4'd3;
   localparam logic [3:0] OP_INC = 4'd4;
   localparam logic [3:0] OP_DEC = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_NEG = 4'd7;
   localparam logic [3:0] OP_MOV = 4'd8;
   localparam logic [3:0] OP_NOT = 4'd9;
   localparam logic [3:0] OP_EXP = 4'd10;
   localparam logic [3:0] OP_AND = 4'd11;
   localparam logic [3:0] OP_OR  = 4'd12;
   localparam logic [3:0] OP_XOR = 4'd13;
   localparam logic [3:0] OP_SHR = 4'd14;
   localparam logic [3:0] OP_SAR = 4'd15;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  a_q, b_q, res_q, res_nxt, a_sw, b_sw;
   logic [3:0]    op_q, flags_q, flags_nxt;
   logic          cin_q, chain, chain_nxt, chain_init, done_q;
   logic [CW-1:0] cnt, pos;
   logic          last, msb_first;
   logic [7:0]    a_byte, b_byte, x_byte, y_byte, byte_out;
   logic [8:0]    sum9;
   logic          a_msb, b_msb, r_msb, v_flag, c_flag;

   assign busy   = (state == S_RUN);
   assign done   = done_q;
   assign flags  = flags_q;
   assign result = n_oe ? {W{1'bz}} : res_q;

   assign a_sw = invert ? b : a;
   assign b_sw = invert ? a : b;

   assign last      = (cnt == '0);
   assign msb_first = (op_q == OP_SHR) || (op_q == OP_SAR);
   assign pos       = msb_first ? cnt : (CW'(BYTES - 1) - cnt);

   // state register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state: leave RUN after the last byte
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_RUN;
         S_RUN:  if (last)  state_nxt = S_IDLE;
         default:           state_nxt = S_IDLE;
      endcase
   end

   // chain seed: INC/DEC inject their +1/-1 as an initial carry/borrow
   always_comb begin
      chain_init = 1'b0;
      case (op)
         OP_INC, OP_DEC: chain_init = 1'b1;
         OP_ADC, OP_SBB: chain_init = carry_in;
         OP_SAR:         chain_init = a_sw[W-1];
         default:        chain_init = 1'b0;
      endcase
   end

   // select the operand bytes at the current position
   always_comb begin
      a_byte = 8'h00;
      b_byte = 8'h00;
      for (int k = 0; k < BYTES; k++) begin
         if (pos == CW'(k)) begin
            a_byte = a_q[k*8 +: 8];
            b_byte = b_q[k*8 +: 8];
         end
      end
   end

   // 8-bit slice: one result byte and the outgoing chain bit
   always_comb begin
      byte_out  = 8'h00;
      chain_nxt = 1'b0;
      sum9      = 9'h000;
      x_byte    = a_byte;
      y_byte    = b_byte;
      case (op_q)
         OP_ADD, OP_ADC, OP_INC: begin
            if (op_q == OP_INC) y_byte = 8'h00;
            sum9      = {1'b0, x_byte} + {1'b0, y_byte} + {8'h00, chain};
            byte_out  = sum9[7:0];
            chain_nxt = sum9[8];
         end
         OP_SUB, OP_SBB, OP_DEC, OP_NEG: begin
            if (op_q == OP_DEC) y_byte = 8'h00;
            if (op_q == OP_NEG) begin
               x_byte = 8'h00;
               y_byte = a_byte;
            end
            sum9      = {1'b0, x_byte} - {1'b0, y_byte} - {8'h00, chain};
            byte_out  = sum9[7:0];
            chain_nxt = sum9[8];
         end
         OP_SHL: begin
            byte_out  = {a_byte[6:0], chain};
            chain_nxt = a_byte[7];
         end
         OP_SHR, OP_SAR: begin
            byte_out  = {chain, a_byte[7:1]};
            chain_nxt = a_byte[0];
         end
         OP_MOV:  byte_out = a_byte;
         OP_NOT:  byte_out = ~a_byte;
         OP_EXP:  byte_out = {8{cin_q}};
         OP_AND:  byte_out = a_byte & b_byte;
         OP_OR:   byte_out = a_byte | b_byte;
         OP_XOR:  byte_out = a_byte ^ b_byte;
         default: byte_out = 8'h00;
      endcase
   end

   // merge the new byte into the result word
   always_comb begin
      res_nxt = res_q;
      for (int k = 0; k < BYTES; k++) begin
         if (pos == CW'(k)) res_nxt[k*8 +: 8] = byte_out;
      end
   end

   // word-level flags, only latched on the last byte
   always_comb begin
      a_msb  = a_q[W-1];
      b_msb  = b_q[W-1];
      r_msb  = res_nxt[W-1];
      v_flag = 1'b0;
      c_flag = 1'b0;
      case (op_q)
         OP_ADD, OP_ADC: v_flag = (a_msb == b_msb) && (r_msb != a_msb);
         OP_SUB, OP_SBB: v_flag = (a_msb != b_msb) && (r_msb != a_msb);
         OP_INC:         v_flag = !a_msb && r_msb;
         OP_DEC:         v_flag = a_msb && !r_msb;
         OP_NEG:         v_flag = (a_q == {1'b1, {(W-1){1'b0}}});
         default:        v_flag = 1'b0;
      endcase
      case (op_q)
         OP_MOV, OP_NOT, OP_EXP, OP_AND, OP_OR, OP_XOR: c_flag = 1'b0;
         default:                                       c_flag = chain_nxt;
      endcase
      flags_nxt = {v_flag, r_msb, c_flag, (res_nxt == '0)};
   end

   // operand latch, byte sequencing, result/flags update
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 4'h0;
         cin_q   <= 1'b0;
         chain   <= 1'b0;
         cnt     <= '0;
         res_q   <= '0;
         flags_q <= 4'h0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state == S_RUN) && last;
         if (state == S_IDLE && start) begin
            a_q   <= a_sw;
            b_q   <= b_sw;
            op_q  <= op;
            cin_q <= carry_in;
            chain <= chain_init;
            cnt   <= CW'(BYTES - 1);
         end else if (state == S_RUN) begin
            res_q <= res_nxt;
            chain <= chain_nxt;
            cnt   <= cnt - 1'b1;
            if (last) flags_q <= flags_nxt;
         end
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// Directed and random checks of alu_serial (BYTES=2) against a word-level
// reference model, using a queue of expected {flags, result} values.
module tb_alu_serial;

   localparam int BYTES = 2;
   localparam int W     = 8 * BYTES;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic         invert, carry_in, n_oe;
   logic         busy, done;
   logic [W-1:0] result;
   logic [3:0]   flags;

   int total = 0;
   int bad   = 0;
   logic [W+3:0] exp_q[$];
   logic [W-1:0] last_res;

   alu_serial #(.BYTES(BYTES)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .op(op), .a(a), .b(b),
      .invert(invert), .carry_in(carry_in), .n_oe(n_oe), .busy(busy),
      .done(done), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   // word-level reference: returns {V, N, C, Z, result}
   function automatic logic [W+3:0] model(logic [3:0] o, logic [W-1:0] x,
                                          logic [W-1:0] y, logic ci);
      logic [W:0]   t;
      logic [W-1:0] r;
      logic         c, v;
      t = '0; r = '0; c = 1'b0; v = 1'b0;
      case (o)
         4'd0, 4'd2, 4'd4: begin
            if (o == 4'd4) t = {1'b0, x} + (W+1)'(1);
            else t = {1'b0, x} + {1'b0, y} + ((o == 4'd2) ? {{W{1'b0}}, ci} : '0);
            r = t[W-1:0]; c = t[W];
            if (o == 4'd4) v = !x[W-1] && r[W-1];
            else           v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
         end
         4'd1, 4'd3: begin
            t = {1'b0, x} - {1'b0, y} - ((o == 4'd3) ? {{W{1'b0}}, ci} : '0);
            r = t[W-1:0]; c = t[W];
            v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
         end
         4'd5: begin
            t = {1'b0, x} - (W+1)'(1);
            r = t[W-1:0]; c = t[W];
            v = x[W-1] && !r[W-1];
         end
         4'd7: begin
            t = {(W+1){1'b0}} - {1'b0, x};
            r = t[W-1:0]; c = t[W];
            v = (x == {1'b1, {(W-1){1'b0}}});
         end
         4'd6:  begin r = {x[W-2:0], 1'b0}; c = x[W-1]; end
         4'd14: begin r = {1'b0, x[W-1:1]}; c = x[0]; end
         4'd15: begin r = {x[W-1], x[W-1:1]}; c = x[0]; end
         4'd8:  r = x;
         4'd9:  r = ~x;
         4'd10: r = {W{ci}};
         4'd11: r = x & y;
         4'd12: r = x | y;
         default: r = x ^ y;
      endcase
      return {v, r[W-1], c, (r == '0), r};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
      total++;
      assert (got === expv)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
      end
   endtask

   // drive a request (called just after a falling edge) and queue its result
   task automatic launch(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y,
                         logic inv, logic ci);
      op = o; a = x; b = y; invert = inv; carry_in = ci; start = 1'b1;
      if (inv) exp_q.push_back(model(o, y, x, ci));
      else     exp_q.push_back(model(o, x, y, ci));
   endtask

   // count falling edges until done, dropping start after the first one
   task automatic wait_done(input int n0, output int n);
      n = n0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
      end while (!done && n < 40);
   endtask

   task automatic check_done(string tag, input int n0);
      int n;
      logic [W+3:0] e;
      wait_done(n0, n);
      chk({tag, "_latency"}, 32'(n), 32'(BYTES + 1));
      chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_result"}, 32'(result), 32'(e[W-1:0]));
         chk({tag, "_flags"}, 32'(flags), 32'(e[W+3:W]));
         last_res = e[W-1:0];
      end
   endtask

   initial begin
      int n;
      n_rst = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
      invert = 1'b0; carry_in = 1'b0; n_oe = 1'b0; last_res = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);

      launch(4'd0, 16'h00ff, 16'h0001, 1'b0, 1'b0);
      chk("add_exp", 32'(exp_q[0]), 32'h00100);
      check_done("add", 0);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      launch(4'd0, 16'h7fff, 16'h0001, 1'b0, 1'b0);
      chk("addv_exp", 32'(exp_q[0]), 32'hc8000);
      check_done("add_ovf", 0);
      // every following launch lands in the done cycle (back-to-back)
      launch(4'd1, 16'h0005, 16'h000a, 1'b0, 1'b0);  check_done("sub", 0);
      chk("sub_const", 32'(result), 32'hfffb);
      chk("sub_fconst", 32'(flags), 32'h6);
      launch(4'd1, 16'h0005, 16'h000a, 1'b1, 1'b0);  check_done("sub_inv", 0);
      chk("subinv_const", 32'(result), 32'h0005);
      launch(4'd14, 16'h0101, 16'h0000, 1'b0, 1'b0); check_done("shr", 0);
      chk("shr_const", 32'(result), 32'h0080);
      chk("shr_fconst", 32'(flags), 32'h2);
      launch(4'd15, 16'h8001, 16'h0000, 1'b0, 1'b0); check_done("sar", 0);
      chk("sar_const", 32'(result), 32'hc000);
      chk("sar_fconst", 32'(flags), 32'h6);
      launch(4'd6, 16'h8080, 16'h0000, 1'b0, 1'b0);  check_done("shl", 0);
      chk("shl_const", 32'(result), 32'h0100);
      launch(4'd10, 16'h1234, 16'h5678, 1'b0, 1'b1); check_done("exp", 0);
      chk("exp_fconst", 32'(flags), 32'h4);
      launch(4'd5, 16'h0000, 16'h0000, 1'b0, 1'b0);  check_done("dec", 0);
      chk("dec_const", 32'(result), 32'hffff);
      chk("dec_fconst", 32'(flags), 32'h6);

      // start while busy must be ignored, inputs may change after start edge
      @(negedge clk);
      launch(4'd0, 16'h1000, 16'h0234, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("busy_set", 32'(busy), 32'd1);
      op = 4'd13; a = 16'hffff; b = 16'h0f0f; invert = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 2;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ignore_latency", 32'(n), 32'(BYTES + 1));
      if (exp_q.size() > 0) begin
         chk("ignore_result", 32'(result), 32'(exp_q[0][W-1:0]));
         last_res = exp_q[0][W-1:0];
         exp_q.delete();
      end
      @(negedge clk);
      chk("ignore_no_restart", 32'(busy), 32'd0);

      // output enable
      n_oe = 1'b1;
      #1;
      total++;
      assert (result === {W{1'bz}})
      else begin
         bad++;
         $error("FAIL oe_hiz: observed=%h expected=zzzz", result);
      end
      n_oe = 1'b0;
      #1;
      chk("oe_restore", 32'(result), 32'(last_res));

      // asynchronous reset in the middle of an operation
      @(negedge clk);
      launch(4'd0, 16'h1234, 16'h1111, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_result", 32'(result), 32'd0);
      chk("mid_rst_flags", 32'(flags), 32'd0);
      exp_q.delete();
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      // random sweep against the reference model
      for (int i = 0; i < 300; i++) begin
         launch(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check_done("rnd", 0);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
